multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Moore FSM that sequences a shared-memory, single-ALU multi-cycle RV32I datapath, one instruction at a time.
- Decodes the same opcode set as the pipeline main decoder: 3, 19, 23, 35, 51, 55, 99, 103, 111.
- Drives all datapath mux selects and write strobes.
- Holds in memory states until the unified memory acknowledges with `mem_ready`.
- Counts retired instructions and flags illegal opcodes.

Parameters:
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- op  in  7  opcode from the instruction register.
- branch_taken  in  1  branch condition result from the comparator.
- mem_ready  in  1  memory acknowledge; completes the current access this cycle.
- mem_req  out  1  memory access request.
- AdrSrc  out  1  address select: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  load instruction register and OldPC.
- PCWrite  out  1  load PC from Result.
- MemWrite  out  1  store strobe.
- RegWrite  out  1  register-file write.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 register.
- ALUSrcB  out  2  ALU B select: 00 = rs2 register, 01 = ImmExt, 10 = constant 4.
- ALUOp  out  2  00 = add, 01 = compare/sub, 10 = funct-decoded.
- ResultSrc  out  2  00 = ALUOut, 01 = read-data register, 10 = ALUResult, 11 = ImmExt.
- ImmSrc  out  3  000 = I, 001 = U, 010 = S, 011 = B, 100 = J.
- illegal_instr  out  1  sticky illegal-opcode flag.
- instret  out  CNT_WIDTH  retired-instruction count.

Behaviour:
- Output defaults in every state unless overridden: all strobes 0, all selects 0.
- Reset (rst = 0, asynchronous):
  - state goes to IDLE; instret = 0; illegal_instr = 0.
  - IDLE drives default outputs only, so mem_req = 0 and all strobes are 0.
  - IDLE lasts one cycle after reset release, then goes to FETCH.
- FETCH:
  - AdrSrc = 0, mem_req = 1, ALUSrcA = 00, ALUSrcB = 10, ALUOp = 00, ResultSrc = 10.
  - IRWrite = PCWrite = mem_ready.
  - Stays in FETCH while mem_ready = 0; goes to DECODE when mem_ready = 1.
- DECODE:
  - ALUSrcA = 01, ALUSrcB = 01, ALUOp = 00; computes the branch/JAL target into ALUOut.
  - ImmSrc = 011 for op 99, 100 for op 111, 000 otherwise.
  - Next state by op: 3/35 → MEMADR, 51 → EXECR, 19 → EXECI, 99 → BRANCH, 111 → JAL, 103 → JALR, 23 → AUIPC, 55 → LUI, any other → ILLEGAL.
- MEMADR:
  - ALUSrcA = 10, ALUSrcB = 01, ALUOp = 00.
  - ImmSrc = 010 if op = 35, else 000.
  - Next: MEMWRITE if op = 35, else MEMREAD.
- MEMREAD: AdrSrc = 1, mem_req = 1; waits for mem_ready, then MEMWB.
- MEMWB: ResultSrc = 01, RegWrite = 1 → FETCH.
- MEMWRITE: AdrSrc = 1, mem_req = 1, MemWrite = 1; MemWrite stays high through wait cycles; goes to FETCH when mem_ready = 1.
- EXECR: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 10 → ALUWB.
- EXECI: ALUSrcA = 10, ALUSrcB = 01, ImmSrc = 000, ALUOp = 10 → ALUWB.
- ALUWB: ResultSrc = 00, RegWrite = 1 → FETCH.
- BRANCH:
  - ALUSrcA = 10, ALUSrcB = 00, ALUOp = 01, ResultSrc = 00.
  - PCWrite = branch_taken.
  - → FETCH.
- JAL:
  - ALUSrcA = 01, ALUSrcB = 10, ALUOp = 00, ResultSrc = 00, PCWrite = 1.
  - PC ← ALUOut target; ALUOut ← OldPC + 4.
  - → ALUWB.
- JALR: ALUSrcA = 10, ALUSrcB = 01, ImmSrc = 000, ALUOp = 00 (target = rs1 + imm into ALUOut) → JAL.
- AUIPC: ALUSrcA = 01, ALUSrcB = 01, ImmSrc = 001, ALUOp = 00 → ALUWB.
- LUI: ImmSrc = 001, ResultSrc = 11, RegWrite = 1 → FETCH.
- ILLEGAL:
  - Default outputs; illegal_instr set to 1 on entry.
  - Terminal state; only reset leaves it.
- Cycle counts with mem_ready tied to 1:
  - R/I/AUIPC/JAL: 4 cycles; JALR: 5.
  - Load: 5; store: 4; branch: 3; LUI: 3.
  - Each cycle of mem_ready = 0 in a memory state adds one cycle.
- instret:
  - Increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB, BRANCH or LUI.
  - Wraps modulo 2^CNT_WIDTH; no increment on IDLE → FETCH.
- mem_ready outside FETCH, MEMREAD and MEMWRITE is ignored.
- Reset mid-access drops mem_req and MemWrite immediately; no partial retire is counted.

Test Plan:
- ADD (op 51), mem_ready = 1 → states FETCH, DECODE, EXECR, ALUWB; RegWrite = 1 only in cycle 4; instret 0 → 1.
- LW (op 3), mem_ready low for 2 cycles in MEMREAD → mem_req high 3 cycles in MEMREAD with AdrSrc = 1; MEMWB has ResultSrc = 01; total 7 cycles.
- BEQ (op 99) run twice, branch_taken = 1 then 0 → PCWrite = 1 then 0 in BRANCH; ImmSrc = 011 in DECODE; instret += 2.
- JALR (op 103) → JALR, JAL (PCWrite = 1), ALUWB (RegWrite = 1); 5 cycles; ImmSrc = 000.
- op = 7'h7F → ILLEGAL reached; illegal_instr = 1 held for 10+ cycles; mem_req = 0; instret unchanged.
- SW with rst asserted during MEMWRITE wait → MemWrite and mem_req go to 0 asynchronously; IDLE, then FETCH after release; instret = 0.

Source files
------------

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore FSM sequencing a multi-cycle RV32I datapath
//
// Purpose: steps one instruction at a time through fetch, decode, execute,
// memory and writeback over a shared memory and a single ALU. Counts retired
// instructions and latches a sticky flag when an unknown opcode is decoded.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   op                opcode from the instruction register
//   branch_taken      comparator result, gates PCWrite in BRANCH
//   mem_ready         memory acknowledge for FETCH / MEMREAD / MEMWRITE
//   mem_req, AdrSrc   memory request and address select (PC / ALUOut)
//   IRWrite, PCWrite  instruction register / PC load strobes
//   MemWrite          store strobe
//   RegWrite          register-file write strobe
//   ALUSrcA, ALUSrcB  ALU operand selects
//   ALUOp             ALU operation class
//   ResultSrc         result bus select
//   ImmSrc            immediate format select
//   illegal_instr     sticky illegal-opcode flag
//   instret           retired-instruction counter (wraps)
module multicycle_controller #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           op,
  input  logic                 branch_taken,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 AdrSrc,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ALUOp,
  output logic [1:0]           ResultSrc,
  output logic [2:0]           ImmSrc,
  output logic                 illegal_instr,
  output logic [CNT_WIDTH-1:0] instret
);

  localparam logic [6:0] OP_LOAD  = 7'd3;
  localparam logic [6:0] OP_ALUI  = 7'd19;
  localparam logic [6:0] OP_AUIPC = 7'd23;
  localparam logic [6:0] OP_STORE = 7'd35;
  localparam logic [6:0] OP_ALUR  = 7'd51;
  localparam logic [6:0] OP_LUI   = 7'd55;
  localparam logic [6:0] OP_BR    = 7'd99;
  localparam logic [6:0] OP_JALR  = 7'd103;
  localparam logic [6:0] OP_JAL   = 7'd111;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_AUIPC, S_LUI,
    S_ILLEGAL
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   instret_q;
  logic                   illegal_q;
  logic                   retire;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_ALUR:           state_d = S_EXECR;
          OP_ALUI:           state_d = S_EXECI;
          OP_BR:             state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_AUIPC:          state_d = S_AUIPC;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      // JALR computes its target into ALUOut, then reuses JAL for PC update and link.
      S_JALR:     state_d = S_JAL;
      S_JAL:      state_d = S_ALUWB;
      S_AUIPC:    state_d = S_ALUWB;
      S_LUI:      state_d = S_FETCH;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output logic (Moore, except the FETCH strobes qualified by the acknowledge)
  always_comb begin
    mem_req   = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    ResultSrc = 2'b00;
    ImmSrc    = 3'b000;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        if (op == OP_BR)       ImmSrc = 3'b011;
        else if (op == OP_JAL) ImmSrc = 3'b100;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        if (op == OP_STORE) ImmSrc = 3'b010;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        mem_req = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        mem_req  = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        PCWrite = branch_taken;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      S_JALR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_AUIPC: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 3'b001;
      end
      S_LUI: begin
        ImmSrc    = 3'b001;
        ResultSrc = 2'b11;
        RegWrite  = 1'b1;
      end
      default: ;
    endcase
  end

  // An instruction retires on the last transition back into FETCH; the
  // IDLE -> FETCH start-up transition does not count.
  assign retire = (state_d == S_FETCH) &&
                  ((state_q == S_MEMWB)  || (state_q == S_MEMWRITE) ||
                   (state_q == S_ALUWB)  || (state_q == S_BRANCH)   ||
                   (state_q == S_LUI));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (retire) instret_q <= instret_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      if (state_d == S_ILLEGAL) illegal_q <= 1'b1;
    end
  end

  assign instret       = instret_q;
  assign illegal_instr = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    op;
  logic          branch_taken;
  logic          mem_ready;
  logic          mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite;
  logic [1:0]    ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
  logic [2:0]    ImmSrc;
  logic          illegal_instr;
  logic [CW-1:0] instret;

  multicycle_controller #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .op(op), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
    .illegal_instr(illegal_instr), .instret(instret)
  );

  always #5 clk = ~clk;

  // Bench-side state tags used to build expected output words.
  localparam logic [3:0] T_IDLE = 4'd0,  T_FETCH = 4'd1,  T_DECODE = 4'd2,
                         T_MEMADR = 4'd3, T_MEMREAD = 4'd4, T_MEMWB = 4'd5,
                         T_MEMWRITE = 4'd6, T_EXECR = 4'd7, T_EXECI = 4'd8,
                         T_ALUWB = 4'd9, T_BRANCH = 4'd10, T_JAL = 4'd11,
                         T_JALR = 4'd12, T_AUIPC = 4'd13, T_LUI = 4'd14,
                         T_ILLEGAL = 4'd15;

  typedef struct {
    string          name;
    logic [6:0]     op;
    logic           bt;
    int             n;
    logic [4:0][3:0] seq;
  } vec_t;

  vec_t          vecs[10];
  logic [16:0]   sb_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [CW-1:0] exp_cnt  = '0;

  wire [16:0] act_word = {mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite,
                          ALUSrcA, ALUSrcB, ALUOp, ResultSrc, ImmSrc};

  function automatic logic [16:0] exp_word(logic [3:0] s, logic [6:0] o,
                                           logic bt, logic mr);
    logic mq, ad, irw, pcw, mw, rw;
    logic [1:0] a, b, aop, res;
    logic [2:0] imm;
    {mq, ad, irw, pcw, mw, rw} = 6'b0;
    a = 2'b00; b = 2'b00; aop = 2'b00; res = 2'b00; imm = 3'b000;
    case (s)
      T_FETCH:    begin mq = 1'b1; irw = mr; pcw = mr; b = 2'b10; res = 2'b10; end
      T_DECODE:   begin a = 2'b01; b = 2'b01;
                        imm = (o == 7'd99) ? 3'b011 : (o == 7'd111) ? 3'b100 : 3'b000; end
      T_MEMADR:   begin a = 2'b10; b = 2'b01; imm = (o == 7'd35) ? 3'b010 : 3'b000; end
      T_MEMREAD:  begin mq = 1'b1; ad = 1'b1; end
      T_MEMWB:    begin res = 2'b01; rw = 1'b1; end
      T_MEMWRITE: begin mq = 1'b1; ad = 1'b1; mw = 1'b1; end
      T_EXECR:    begin a = 2'b10; aop = 2'b10; end
      T_EXECI:    begin a = 2'b10; b = 2'b01; aop = 2'b10; end
      T_ALUWB:    begin rw = 1'b1; end
      T_BRANCH:   begin a = 2'b10; aop = 2'b01; pcw = bt; end
      T_JAL:      begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
      T_JALR:     begin a = 2'b10; b = 2'b01; end
      T_AUIPC:    begin a = 2'b01; b = 2'b01; imm = 3'b001; end
      T_LUI:      begin imm = 3'b001; res = 2'b11; rw = 1'b1; end
      default: ;
    endcase
    return {mq, ad, irw, pcw, mw, rw, a, b, aop, res, imm};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Entered and left at posedge+1: drive, queue the expectation, compare on
  // the falling edge, then advance to the next cycle.
  task automatic step(input logic mr, input logic [16:0] exp, input string name);
    logic [16:0] e;
    mem_ready = mr;
    sb_q.push_back(exp);
    @(negedge clk);
    e = sb_q.pop_front();
    check(name, {15'd0, act_word}, {15'd0, e});
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int pass);
    op = v.op;
    branch_taken = v.bt;
    for (int i = 0; i < v.n; i++)
      step(1'b1, exp_word(v.seq[i], v.op, v.bt, 1'b1),
           $sformatf("%s p%0d cyc%0d", v.name, pass, i));
    exp_cnt = exp_cnt + 1'b1;
    check($sformatf("%s p%0d instret", v.name, pass), {28'd0, instret}, {28'd0, exp_cnt});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"ADD",   7'd51,  1'b0, 4, {T_IDLE, T_ALUWB, T_EXECR, T_DECODE, T_FETCH}};
    vecs[1] = '{"ADDI",  7'd19,  1'b0, 4, {T_IDLE, T_ALUWB, T_EXECI, T_DECODE, T_FETCH}};
    vecs[2] = '{"AUIPC", 7'd23,  1'b0, 4, {T_IDLE, T_ALUWB, T_AUIPC, T_DECODE, T_FETCH}};
    vecs[3] = '{"LUI",   7'd55,  1'b0, 3, {T_IDLE, T_IDLE, T_LUI, T_DECODE, T_FETCH}};
    vecs[4] = '{"LW",    7'd3,   1'b0, 5, {T_MEMWB, T_MEMREAD, T_MEMADR, T_DECODE, T_FETCH}};
    vecs[5] = '{"SW",    7'd35,  1'b0, 4, {T_IDLE, T_MEMWRITE, T_MEMADR, T_DECODE, T_FETCH}};
    vecs[6] = '{"BEQt",  7'd99,  1'b1, 3, {T_IDLE, T_IDLE, T_BRANCH, T_DECODE, T_FETCH}};
    vecs[7] = '{"BEQn",  7'd99,  1'b0, 3, {T_IDLE, T_IDLE, T_BRANCH, T_DECODE, T_FETCH}};
    vecs[8] = '{"JAL",   7'd111, 1'b0, 4, {T_IDLE, T_ALUWB, T_JAL, T_DECODE, T_FETCH}};
    vecs[9] = '{"JALR",  7'd103, 1'b0, 5, {T_ALUWB, T_JAL, T_JALR, T_DECODE, T_FETCH}};

    rst = 1'b0; op = 7'd0; branch_taken = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    check("reset outputs", {15'd0, act_word}, 32'd0);
    check("reset instret", {28'd0, instret}, 32'd0);
    check("reset illegal", {31'd0, illegal_instr}, 32'd0);
    rst = 1'b1;
    step(1'b1, exp_word(T_IDLE, 7'd0, 1'b0, 1'b1), "idle after reset");

    // Two passes over the table: 20 retirements wrap the 4-bit counter.
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 10; i++)
        run_vec(vecs[i], p);

    // Load with two wait cycles in MEMREAD: 7 cycles total.
    op = 7'd3;
    step(1'b1, exp_word(T_FETCH,   op, 1'b0, 1'b1), "LWw fetch");
    step(1'b0, exp_word(T_DECODE,  op, 1'b0, 1'b0), "LWw decode");
    step(1'b0, exp_word(T_MEMADR,  op, 1'b0, 1'b0), "LWw memadr");
    step(1'b0, exp_word(T_MEMREAD, op, 1'b0, 1'b0), "LWw wait0");
    step(1'b0, exp_word(T_MEMREAD, op, 1'b0, 1'b0), "LWw wait1");
    step(1'b1, exp_word(T_MEMREAD, op, 1'b0, 1'b1), "LWw ack");
    step(1'b1, exp_word(T_MEMWB,   op, 1'b0, 1'b1), "LWw memwb");
    exp_cnt = exp_cnt + 1'b1;
    check("LWw instret", {28'd0, instret}, {28'd0, exp_cnt});

    // Illegal opcode: terminal, sticky flag, no retire, mem_ready ignored.
    op = 7'h7F;
    step(1'b1, exp_word(T_FETCH, op, 1'b0, 1'b1), "ILL fetch");
    check("ILL flag before", {31'd0, illegal_instr}, 32'd0);
    step(1'b1, exp_word(T_DECODE, op, 1'b0, 1'b1), "ILL decode");
    for (int i = 0; i < 12; i++) begin
      step(i[0], exp_word(T_ILLEGAL, op, 1'b0, i[0]), $sformatf("ILL hold%0d", i));
      check($sformatf("ILL flag%0d", i), {31'd0, illegal_instr}, 32'd1);
    end
    check("ILL instret", {28'd0, instret}, {28'd0, exp_cnt});

    rst = 1'b0; #1;
    check("rst2 flag", {31'd0, illegal_instr}, 32'd0);
    check("rst2 instret", {28'd0, instret}, 32'd0);
    exp_cnt = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    step(1'b1, exp_word(T_IDLE, op, 1'b0, 1'b1), "rst2 idle");

    // Store interrupted by reset while waiting on memory.
    op = 7'd35;
    step(1'b0, exp_word(T_FETCH,    op, 1'b0, 1'b0), "SWr fetch wait");
    step(1'b1, exp_word(T_FETCH,    op, 1'b0, 1'b1), "SWr fetch");
    step(1'b1, exp_word(T_DECODE,   op, 1'b0, 1'b1), "SWr decode");
    step(1'b1, exp_word(T_MEMADR,   op, 1'b0, 1'b1), "SWr memadr");
    step(1'b0, exp_word(T_MEMWRITE, op, 1'b0, 1'b0), "SWr wait0");
    step(1'b0, exp_word(T_MEMWRITE, op, 1'b0, 1'b0), "SWr wait1");
    #2 rst = 1'b0; #1;
    check("SWr async MemWrite", {31'd0, MemWrite}, 32'd0);
    check("SWr async mem_req", {31'd0, mem_req}, 32'd0);
    check("SWr async outputs", {15'd0, act_word}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    step(1'b1, exp_word(T_IDLE,  op, 1'b0, 1'b1), "SWr idle");
    step(1'b1, exp_word(T_FETCH, op, 1'b0, 1'b1), "SWr refetch");
    check("SWr instret", {28'd0, instret}, 32'd0);
    check("scoreboard drained", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
